// File: rtl/tmr_pkg.sv
// Shared types and constants for the NFC triple-modular-redundancy fault monitor.
// Bundle layout (MSB..LSB): done, IO_A_OUT, A ctl, IO_B_OUT, B ctl, READING.
package tmr_pkg;

    typedef enum logic [1:0] {
        MODE_TMR    = 2'd0,
        MODE_DUPLEX = 2'd1,
        MODE_FAIL   = 2'd2
    } mode_t;

    localparam int NFC_BUNDLE_W   = 27;

    localparam int BUNDLE_DONE    = 26;
    localparam int BUNDLE_IO_A    = 18;
    localparam int BUNDLE_CTL_A   = 14;
    localparam int BUNDLE_IO_B    = 6;
    localparam int BUNDLE_CTL_B   = 2;
    localparam int BUNDLE_READING = 0;

endpackage

// File: rtl/tmr_fault_monitor_if.sv
// Replica/voted bundle interface for tmr_fault_monitor.
// TMR_ERR_INJECT_EN adds the per-replica error-injection strobes.
interface tmr_fault_monitor_if #(
    parameter int W     = 27,
    parameter int CNT_W = 16
);
    logic [W-1:0]     rep_a;
    logic [W-1:0]     rep_b;
    logic [W-1:0]     rep_c;
    logic             clr_fault;
`ifdef TMR_ERR_INJECT_EN
    logic             err_inj_a;
    logic             err_inj_b;
    logic             err_inj_c;
`endif
    logic [W-1:0]     voted;
    logic             fault_a;
    logic             fault_b;
    logic             fault_c;
    logic [1:0]       mode;
    logic             tmr_error;
    logic [CNT_W-1:0] mismatch_cnt;

    modport master (
        output rep_a, rep_b, rep_c, clr_fault,
`ifdef TMR_ERR_INJECT_EN
        output err_inj_a, err_inj_b, err_inj_c,
`endif
        input  voted, fault_a, fault_b, fault_c, mode, tmr_error, mismatch_cnt
    );

    modport slave (
        input  rep_a, rep_b, rep_c, clr_fault,
`ifdef TMR_ERR_INJECT_EN
        input  err_inj_a, err_inj_b, err_inj_c,
`endif
        output voted, fault_a, fault_b, fault_c, mode, tmr_error, mismatch_cnt
    );

endinterface

// File: rtl/tmr_lane_tracker.sv
// Per-replica persistence counter with sticky fault flag.
// trip flags the cycle whose edge latches the fault so the mode FSM can switch on that same edge.
module tmr_lane_tracker #(
    parameter int PERSIST = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic dissent,
    output logic fault,
    output logic trip
);
    localparam int CW = 4;

    logic [CW-1:0] cnt;

    assign trip = en && dissent && !fault && (cnt == CW'(PERSIST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            fault <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            fault <= 1'b0;
        end else if (en) begin
            if (dissent) begin
                if (cnt != CW'(PERSIST))
                    cnt <= cnt + 1'b1;
                if (trip)
                    fault <= 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Votes three NFC replica bundles, latches persistent dissenters and degrades TMR -> DUPLEX -> FAIL.
// Optional TMR_ERR_INJECT_EN: err_inj_x inverts replica x before compare and vote.
module tmr_fault_monitor
    import tmr_pkg::*;
#(
    parameter int W       = NFC_BUNDLE_W,
    parameter int PERSIST = 3,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    tmr_fault_monitor_if.slave bus
);
    logic [W-1:0] a, b, c;

`ifdef TMR_ERR_INJECT_EN
    assign a = bus.rep_a ^ {W{bus.err_inj_a}};
    assign b = bus.rep_b ^ {W{bus.err_inj_b}};
    assign c = bus.rep_c ^ {W{bus.err_inj_c}};
`else
    assign a = bus.rep_a;
    assign b = bus.rep_b;
    assign c = bus.rep_c;
`endif

    logic         eq_ab, eq_ac, eq_bc, triple;
    logic [W-1:0] maj;
    logic [2:0]   dissent, trip, fault;

    assign eq_ab      = (a == b);
    assign eq_ac      = (a == c);
    assign eq_bc      = (b == c);
    assign triple     = !eq_ab && !eq_ac && !eq_bc;
    assign maj        = (a & b) | (a & c) | (b & c);
    assign dissent[0] = !eq_ab && !eq_ac;
    assign dissent[1] = !eq_ab && !eq_bc;
    assign dissent[2] = !eq_ac && !eq_bc;

    mode_t mode_q, mode_d;
    logic  track_en;

    // A triple disagreement has no sole dissenter, so the lane counters hold while FAIL is entered.
    assign track_en = (mode_q == MODE_TMR) && !triple;

    tmr_lane_tracker #(.PERSIST(PERSIST)) u_lane_a (
        .clk(clk), .rst(rst), .clr(bus.clr_fault), .en(track_en),
        .dissent(dissent[0]), .fault(fault[0]), .trip(trip[0])
    );
    tmr_lane_tracker #(.PERSIST(PERSIST)) u_lane_b (
        .clk(clk), .rst(rst), .clr(bus.clr_fault), .en(track_en),
        .dissent(dissent[1]), .fault(fault[1]), .trip(trip[1])
    );
    tmr_lane_tracker #(.PERSIST(PERSIST)) u_lane_c (
        .clk(clk), .rst(rst), .clr(bus.clr_fault), .en(track_en),
        .dissent(dissent[2]), .fault(fault[2]), .trip(trip[2])
    );

    logic [W-1:0] pair_x, pair_y;
    logic         pair_eq;

    always_comb begin
        pair_x = a;
        pair_y = b;
        if (fault[0]) begin
            pair_x = b;
            pair_y = c;
        end else if (fault[1]) begin
            pair_x = a;
            pair_y = c;
        end
    end

    assign pair_eq = (pair_x == pair_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= MODE_TMR;
        else     mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (bus.clr_fault) begin
            mode_d = MODE_TMR;
        end else begin
            case (mode_q)
                MODE_TMR: begin
                    if (triple)     mode_d = MODE_FAIL;
                    else if (|trip) mode_d = MODE_DUPLEX;
                end
                MODE_DUPLEX: if (!pair_eq) mode_d = MODE_FAIL;
                default:     mode_d = mode_q;
            endcase
        end
    end

    logic         vote_load, mismatch_seen;
    logic [W-1:0] vote_val;

    // clr_fault still loads the plain majority even out of DUPLEX/FAIL.
    always_comb begin
        vote_load     = 1'b0;
        vote_val      = maj;
        mismatch_seen = 1'b0;
        case (mode_q)
            MODE_TMR: begin
                mismatch_seen = !(eq_ab && eq_ac);
                vote_load     = !triple;
            end
            MODE_DUPLEX: begin
                mismatch_seen = !pair_eq;
                vote_load     = pair_eq;
                vote_val      = pair_x;
            end
            default: ;
        endcase
        if (bus.clr_fault) begin
            vote_load = 1'b1;
            vote_val  = maj;
        end
    end

    logic [W-1:0]     voted_q;
    logic             tmr_error_q;
    logic [CNT_W-1:0] mismatch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voted_q     <= '0;
            tmr_error_q <= 1'b0;
            mismatch_q  <= '0;
        end else begin
            if (vote_load)
                voted_q <= vote_val;
            if (bus.clr_fault)
                tmr_error_q <= 1'b0;
            else if (mode_d == MODE_FAIL)
                tmr_error_q <= 1'b1;
            if (mismatch_seen && (mismatch_q != {CNT_W{1'b1}}))
                mismatch_q <= mismatch_q + 1'b1;
        end
    end

    assign bus.voted        = voted_q;
    assign bus.tmr_error    = tmr_error_q;
    assign bus.mismatch_cnt = mismatch_q;
    assign bus.fault_a      = fault[0];
    assign bus.fault_b      = fault[1];
    assign bus.fault_c      = fault[2];
    assign bus.mode         = mode_q;

endmodule
